// File: rtl/dac_serial_out_if.sv
// dac_serial_out_if: sample request and DAC serial bus signals for dac_serial_out
interface dac_serial_out_if;
  logic       Start;
  logic [7:0] Data_in;
  logic       SCLK;
  logic       SYNC;
  logic       DIN;
  logic       Busy;
  logic       Done;
  modport master (output Start, Data_in, input SCLK, SYNC, DIN, Busy, Done);
  modport slave (input Start, Data_in, output SCLK, SYNC, DIN, Busy, Done);
endinterface

// File: rtl/dac_serial_out.sv
// dac_serial_out: shifts one 16-bit frame {00, 00, code[7:0], 0000} MSB first to a serial DAC
module dac_serial_out #(
  parameter int DIV = 2
) (
  input logic CLK,
  input logic Reset,
  dac_serial_out_if.slave dac
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_n;
  logic [15:0] sh, sh_n;
  logic sclk, sclk_n, sync, sync_n;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      sclk <= 1'b1;
      sync <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      sclk <= sclk_n;
      sync <= sync_n;
    end
  // DIN is the shift register MSB; it advances only when SCLK returns high
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_n = bit_cnt;
    sh_n = sh;
    sclk_n = sclk;
    sync_n = sync;
    case (state)
      IDLE: if (dac.Start) begin
        state_n = SHIFT;
        sh_n = {4'b0000, dac.Data_in, 4'b0000};
        cnt_n = '0;
        bit_n = 4'd15;
        sclk_n = 1'b1;
        sync_n = 1'b0;
      end
      SHIFT: if (cnt != 8'(DIV - 1)) cnt_n = cnt + 8'd1;
      else begin
        cnt_n = '0;
        if (sclk) sclk_n = 1'b0;
        else if (bit_cnt == 4'd0) begin
          state_n = DONE;
          sclk_n = 1'b1;
          sync_n = 1'b1;
          sh_n = '0;
        end else begin
          bit_n = bit_cnt - 4'd1;
          sclk_n = 1'b1;
          sh_n = {sh[14:0], 1'b0};
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign dac.SCLK = sclk;
  assign dac.SYNC = sync;
  assign dac.DIN = sh[15];
  assign dac.Busy = state != IDLE;
  assign dac.Done = state == DONE;
endmodule

// File: tb/tb_dac_serial_out.sv
// tb_dac_serial_out: random frames on DIV=2 and DIV=1 instances checked against a frame-level model
module tb_dac_serial_out;
  logic CLK, Reset, sel, start;
  logic [7:0] data;
  int checks, errors;
  dac_serial_out_if a ();
  dac_serial_out_if b ();
  dac_serial_out #(.DIV(2)) u2 (.CLK(CLK), .Reset(Reset), .dac(a.slave));
  dac_serial_out #(.DIV(1)) u1 (.CLK(CLK), .Reset(Reset), .dac(b.slave));
  assign a.Start = start & !sel;
  assign b.Start = start & sel;
  assign a.Data_in = data;
  assign b.Data_in = data;
  logic m_sclk, m_sync, m_din, m_busy, m_done;
  assign m_sclk = sel ? b.SCLK : a.SCLK;
  assign m_sync = sel ? b.SYNC : a.SYNC;
  assign m_din = sel ? b.DIN : a.DIN;
  assign m_busy = sel ? b.Busy : a.Busy;
  assign m_done = sel ? b.Done : a.Done;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic [15:0] o_word;
  int o_low, o_nd, o_done_at, o_first, o_last, o_falls;
  logic o_bad_phase, o_bad_din, o_bad_busy;
  logic [2:0] o_entry;
  logic [3:0] o_exit;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge CLK);
    start = 1'b1;
    data = d;
  endtask
  task automatic observe(input int div, input int repulse_at, input int rst_at, input bit done_start);
    int run;
    logic ps, pl, held;
    o_word = '0; o_low = 0; o_nd = 0; o_done_at = 0; o_first = 0; o_last = 0; o_falls = 0;
    o_bad_phase = 0; o_bad_din = 0; o_bad_busy = 0; o_entry = '0; o_exit = '0;
    ps = 1'b1; pl = 1'b0; held = 1'b0; run = 0;
    for (int i = 1; i <= 40 * div + 10; i++) begin
      @(negedge CLK);
      if (m_sclk !== ps && pl) begin
        if (run != div) o_bad_phase = 1'b1;
        run = 1;
      end else run++;
      if (ps && !m_sclk && !m_sync) begin
        o_word = {o_word[14:0], m_din};
        o_falls++;
        held = m_din;
      end else if (!m_sclk && !m_sync && m_din !== held) o_bad_din = 1'b1;
      if (!m_sync) begin
        o_low++;
        if (o_first == 0) o_first = i;
        o_last = i;
        if (!m_busy) o_bad_busy = 1'b1;
      end
      if (i == 1) begin
        o_entry = {m_sync, m_sclk, m_din};
        start = 1'b0;
        data = 8'($urandom);
      end
      if (i == repulse_at) begin
        start = 1'b1;
        data = ~data;
      end
      if (i == repulse_at + 1) start = 1'b0;
      if (i == rst_at) begin
        Reset = 1'b1;
        #1;
        check("rst_async", 32'({m_sync, m_sclk, m_din, m_busy, m_done}), 32'b11000);
      end
      if (i == rst_at + 1) Reset = 1'b0;
      ps = m_sclk;
      pl = !m_sync;
      if (m_done) begin
        o_nd++;
        if (o_done_at == 0) o_done_at = i;
        o_exit = {m_sync, m_sclk, m_din, m_busy};
        if (done_start) begin
          start = 1'b1;
          data = 8'($urandom);
        end
        break;
      end
    end
  endtask
  task automatic check_frame(input logic [7:0] d, input int div);
    check("word", 32'(o_word), 32'(d) * 16);
    check("sync_low", 32'(o_low), 32'(32 * div));
    check("sync_first", 32'(o_first), 32'd1);
    check("sync_last", 32'(o_last), 32'(32 * div));
    check("falls", 32'(o_falls), 32'd16);
    check("done_cnt", 32'(o_nd), 32'd1);
    check("done_at", 32'(o_done_at), 32'(32 * div + 1));
    check("phase_len", 32'(o_bad_phase), 32'd0);
    check("din_stable", 32'(o_bad_din), 32'd0);
    check("busy", 32'(o_bad_busy), 32'd0);
    check("entry", 32'(o_entry), 32'b010);
    check("exit", 32'(o_exit), 32'b1101);
  endtask
  initial begin
    logic [7:0] d;
    logic bad;
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    sel = 1'b0;
    start = 1'b0;
    data = '0;
    repeat (3) @(negedge CLK);
    check("reset_a", 32'({a.SYNC, a.SCLK, a.DIN, a.Busy, a.Done}), 32'b11000);
    check("reset_b", 32'({b.SYNC, b.SCLK, b.DIN, b.Busy, b.Done}), 32'b11000);
    Reset = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_a", 32'({a.SYNC, a.SCLK, a.DIN, a.Busy, a.Done}), 32'b11000);
    send(8'h80);
    observe(2, 0, 0, 0);
    check_frame(8'h80, 2);
    send(8'hFF);
    observe(2, 0, 0, 0);
    check_frame(8'hFF, 2);
    send(8'h00);
    observe(2, 0, 0, 0);
    check_frame(8'h00, 2);
    send(8'h3C);
    observe(2, 10, 0, 0);
    check_frame(8'h3C, 2);
    send(8'h5A);
    observe(2, 0, 0, 1);
    check_frame(8'h5A, 2);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      start = 1'b0;
      if (!m_sync || m_busy) bad = 1'b1;
    end
    check("start_in_done", 32'(bad), 32'd0);
    send(8'hC3);
    observe(2, 0, 30, 0);
    check("rst_no_done", 32'(o_nd), 32'd0);
    check("rst_idle", 32'({m_sync, m_sclk, m_din, m_busy}), 32'b1100);
    send(8'h96);
    observe(2, 0, 0, 0);
    check_frame(8'h96, 2);
    sel = 1'b1;
    @(negedge CLK);
    send(8'hA5);
    observe(1, 0, 0, 0);
    check_frame(8'hA5, 1);
    for (int k = 0; k < 8; k++) begin
      sel = 1'($urandom);
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send(d);
      observe(sel ? 1 : 2, 0, 0, 0);
      check_frame(d, sel ? 1 : 2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_serial_out.md
DAC_SERIAL_OUT -- requirements
Module: dac_serial_out

Interface
REQ-001 The block SHALL have parameter DIV, default 2, meaning CLK cycles per SCLK half-period (legal range 1..255).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port Start  input  1  single-cycle request to transmit one sample.
REQ-005 The block SHALL have port Data_in  input  8  offset-binary sample from the offset stage (0x80 = mid-scale 1.65 V).
REQ-006 The block SHALL have port SCLK  output  1  DAC serial clock; idles high.
REQ-007 The block SHALL have port SYNC  output  1  DAC frame select, active-low.
REQ-008 The block SHALL have port DIN  output  1  DAC serial data, MSB first.
REQ-009 The block SHALL have port Busy  output  1  high while a frame is in progress (SHIFT or DONE state).
REQ-010 The block SHALL have port Done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-012 In IDLE, Start=1 SHALL latch the frame word {2'b00, 2'b00, Data_in, 4'b0000} (16 bits: don't-care bits, normal-mode power-down bits 00, 12-bit DAC code) and move to SHIFT on the same edge.
REQ-013 Data_in SHALL be sampled only on the accepted Start edge; later changes SHALL NOT affect the frame in progress.
REQ-014 On entry to SHIFT, the block SHALL drive SYNC=0, SCLK=1 and DIN=bit 15 of the frame word.
REQ-015 Each bit SHALL occupy 2*DIV CLK cycles: SCLK high for DIV cycles, then low for DIV cycles (the DAC samples DIN on the falling SCLK edge).
REQ-016 DIN SHALL change only on a rising SCLK transition, to the next lower bit, and SHALL be stable across the entire low phase.
REQ-017 The half-period divider counter SHALL count 0..DIV-1 and wrap; the bit counter SHALL count 15 down to 0.
REQ-018 After the low phase of bit 0, the block SHALL enter DONE with SCLK=1, SYNC=1 and DIN=0.
REQ-019 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-020 SYNC SHALL be low for exactly 32*DIV consecutive CLK cycles per frame.
REQ-021 Start asserted while Busy=1 SHALL be ignored; there is no queueing.
REQ-022 Start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; Start is accepted only when sampled in IDLE.
REQ-023 Back-to-back frames SHALL therefore have SYNC high for at least 2 CLK cycles between them (DONE plus IDLE).
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from Start or Data_in to SCLK, SYNC or DIN.

Reset
REQ-025 While Reset=1, the block SHALL hold state=IDLE, SCLK=1, SYNC=1, DIN=0, Busy=0, Done=0, and clear both counters and the shift register, independent of CLK.
REQ-026 A reset asserted mid-frame SHALL abort the frame immediately with no Done pulse; the first Start after release SHALL begin a complete fresh frame.
REQ-027 In IDLE, outputs SHALL hold their reset values.

Verification
REQ-028 DIV=2, Data_in=0x80, one Start pulse -> SYNC low for 64 cycles; DIN sequence is 0000_1000_0000_0000; each bit is stable on its SCLK falling edge; Done pulses once 65 cycles after Start.
REQ-029 DIV=2, Data_in=0xFF then 0x00 as two frames, each Start issued on the cycle after Done -> DAC codes 0xFF0 and 0x000 are captured; SYNC is high for at least 2 cycles between frames.
REQ-030 Start re-pulsed at cycle 10 of a frame with a different Data_in -> pulse ignored; original frame completes unchanged; exactly one Done.
REQ-031 Reset asserted at cycle 30 of a frame -> SYNC=1, SCLK=1, DIN=0, Busy=0 asynchronously; no Done; the next Start produces a full 64-cycle frame.
REQ-032 DIV=1, Data_in=0xA5 -> SCLK period is 2 CLK cycles; SYNC low for 32 cycles; captured code is 0xA50.
